seg_serial_driver: RTL and testbench

//   Serialises a frame of 7-segment patterns onto the board's shift-register display chain.

---
 rtl/seg_serial_driver_if.sv | 23 ++
 rtl/seg_serial_driver.sv | 107 ++++++++++
 tb/tb_seg_serial_driver.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_serial_driver_if.sv
// Frame-load handshake between the display register and the serial driver.
interface seg_serial_driver_if #(
  parameter int FW = 64
);
  logic          load_valid;
  logic [FW-1:0] load_data;
  logic          load_ready;
  logic          busy;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready,
    input  busy
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready,
    output busy
  );
endinterface

// File: rtl/seg_serial_driver.sv
// Shifts one accepted frame MSB-first onto the 7-segment register chain; FW*2*CLK_DIV cycles per frame.
// Accepts a frame only in IDLE; load_valid during CLEAR or SHIFT is ignored, not queued.
module seg_serial_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 4,
  parameter int CLR_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  seg_serial_driver_if.slave  load,
  output logic                SEGCLK,
  output logic                SEGDT,
  output logic                SEGCLR,
  output logic                SEGEN
);

  localparam int FW  = 8 * NUM_DIGITS;
  localparam int BCW = $clog2(FW) + 1;
  localparam int HCW = $clog2(CLK_DIV) + 1;
  localparam int CCW = $clog2(CLR_CYCLES + 1) + 1;

  localparam logic [BCW-1:0] BC_LAST  = BCW'(FW - 1);
  localparam logic [HCW-1:0] HC_LAST  = HCW'(CLK_DIV - 1);
  localparam logic [CCW-1:0] CLR_LAST = CCW'(CLR_CYCLES);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t          state;
  logic [CCW-1:0]  cnt;
  logic [HCW-1:0]  hc;
  logic [BCW-1:0]  bc;
  logic [FW-1:0]   sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_CLEAR;
      cnt             <= '0;
      hc              <= '0;
      bc              <= '0;
      sr              <= '0;
      SEGCLK          <= 1'b0;
      SEGDT           <= 1'b0;
      SEGCLR          <= 1'b0;
      SEGEN           <= 1'b0;
      load.load_ready <= 1'b0;
      load.busy       <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          // cnt reaches CLR_CYCLES after that many full low cycles of SEGCLR
          if (cnt == CLR_LAST) begin
            SEGCLR          <= 1'b1;
            load.load_ready <= 1'b1;
            load.busy       <= 1'b0;
            state           <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_IDLE: begin
          if (load.load_valid && load.load_ready) begin
            sr              <= load.load_data;
            SEGDT           <= load.load_data[FW-1];
            hc              <= '0;
            bc              <= '0;
            load.load_ready <= 1'b0;
            load.busy       <= 1'b1;
            state           <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (hc != HC_LAST) begin
            hc <= hc + 1'b1;
          end else begin
            hc <= '0;
            if (!SEGCLK) begin
              SEGCLK <= 1'b1;
            end else begin
              // falling SEGCLK: data only moves while the chain clock is low
              SEGCLK <= 1'b0;
              if (bc == BC_LAST) begin
                SEGDT           <= 1'b0;
                SEGEN           <= 1'b1;
                load.load_ready <= 1'b1;
                load.busy       <= 1'b0;
                state           <= ST_IDLE;
              end else begin
                sr    <= {sr[FW-2:0], 1'b0};
                SEGDT <= sr[FW-2];
                bc    <= bc + 1'b1;
              end
            end
          end
        end

        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_serial_driver.sv
// Bench for seg_serial_driver: vector table, back-to-back, mid-frame reset and random frames
// against a per-cycle timing model derived from bit index and phase arithmetic.
module tb_seg_serial_driver;

  localparam int ND      = 8;
  localparam int DIV     = 2;
  localparam int CLR     = 4;
  localparam int FW      = 8 * ND;
  localparam int PER     = 2 * DIV;
  localparam int FRAME   = FW * PER;
  localparam int ABORT_K = 30 * PER + DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic SEGCLK, SEGDT, SEGCLR, SEGEN;

  int checks   = 0;
  int failures = 0;
  bit exp_en   = 1'b0;

  seg_serial_driver_if #(.FW(FW)) bus ();

  seg_serial_driver #(
    .NUM_DIGITS (ND),
    .CLK_DIV    (DIV),
    .CLR_CYCLES (CLR)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (bus.slave),
    .SEGCLK (SEGCLK),
    .SEGDT  (SEGDT),
    .SEGCLR (SEGCLR),
    .SEGEN  (SEGEN)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [63:0] exp_word;
    int          exp_rises;
    int          exp_busy;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // {SEGCLR, SEGCLK, SEGDT, SEGEN, load_ready, busy}
  function automatic logic [5:0] pins();
    return {SEGCLR, SEGCLK, SEGDT, SEGEN, bus.load_ready, bus.busy};
  endfunction

  // Expected pins k cycles after the accepting edge of frame d.
  function automatic logic [5:0] model(input logic [63:0] d, input int k, input bit en);
    logic hi;
    logic bitv;
    if (k >= FRAME) return 6'b100110;
    hi   = ((k % PER) >= DIV);
    bitv = d[FW - 1 - (k / PER)];
    return {1'b1, hi, bitv, en, 1'b0, 1'b1};
  endfunction

  // Called with rst low at a negedge; releases reset and checks the CLEAR sequence.
  task automatic clear_seq(input bit pulse_valid);
    chk("reset_values", 64'(pins()), 64'(6'b000001));
    exp_en = 1'b0;
    rst = 1'b1;
    for (int i = 1; i <= CLR + 6; i++) begin
      @(negedge clk);
      chk("clear_segclr", 64'(SEGCLR), 64'(i > CLR));
      chk("clear_ready",  64'(bus.load_ready), 64'(i > CLR));
      chk("clear_busy",   64'(bus.busy), 64'(i <= CLR));
      chk("clear_pins_quiet", 64'({SEGCLK, SEGDT, SEGEN}), 64'(3'b000));
      bus.load_valid = pulse_valid && (i < CLR);
      bus.load_data  = {$urandom, $urandom};
    end
    bus.load_valid = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; runs one frame and returns captured data.
  task automatic run_frame(input logic [63:0] d, input bit hold, input logic [63:0] nxt,
                           output logic [63:0] cap, output int rises, output int busy_n,
                           output int viol, output int gap_err);
    int   nbad;
    int   last_rise;
    logic pclk, pdt;
    logic [5:0] act, exp;
    chk("ready_before_load", 64'(bus.load_ready), 64'd1);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    nbad = 0; cap = '0; rises = 0; busy_n = 0; viol = 0; gap_err = 0;
    last_rise = -1; pclk = 1'b0; pdt = 1'b0;
    for (int k = 0; k <= FRAME; k++) begin
      @(negedge clk);
      act = pins();
      exp = model(d, k, exp_en);
      if (act !== exp) begin
        if (nbad == 0) $display("  first frame diff at k=%0d got=%b want=%b", k, act, exp);
        nbad++;
      end
      if (bus.busy) busy_n++;
      if (SEGCLK && !pclk) begin
        rises++;
        cap = {cap[62:0], SEGDT};
        if (last_rise >= 0 && (k - last_rise) != PER) gap_err++;
        last_rise = k;
      end
      if (SEGCLK && pclk && (SEGDT !== pdt)) viol++;
      pclk = SEGCLK;
      pdt  = SEGDT;
      if (!hold) begin
        if (k == 0) begin
          bus.load_valid = 1'b0;
          bus.load_data  = {$urandom, $urandom};
        end
      end else begin
        if (k == FW)        bus.load_data = ~d;
        if (k == FRAME - 1) bus.load_data = nxt;
      end
    end
    chk("frame_trace_bad_cycles", 64'(nbad), 64'd0);
    exp_en = 1'b1;
  endtask

  initial begin
    vec_t        tbl [4];
    logic [63:0] cap, d, a, b;
    int          rises, busy_n, viol, gerr, nbad, gap;

    tbl[0] = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 64, 256};
    tbl[1] = '{64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5, 64, 256};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64, 256};
    tbl[3] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 64, 256};

    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    repeat (3) @(negedge clk);
    clear_seq(1'b1);

    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i].data, 1'b0, 64'd0, cap, rises, busy_n, viol, gerr);
      chk("vec_word",      cap, tbl[i].exp_word);
      chk("vec_rises",     64'(rises), 64'(tbl[i].exp_rises));
      chk("vec_busy",      64'(busy_n), 64'(tbl[i].exp_busy));
      chk("vec_dt_stable", 64'(viol), 64'd0);
      chk("vec_clk_gap",   64'(gerr), 64'd0);
    end

    a = 64'h0123_4567_89AB_CDEF;
    b = ~a;
    run_frame(a, 1'b1, b, cap, rises, busy_n, viol, gerr);
    chk("b2b_word0", cap, a);
    run_frame(b, 1'b1, a, cap, rises, busy_n, viol, gerr);
    chk("b2b_word1", cap, b);
    run_frame(a, 1'b0, 64'd0, cap, rises, busy_n, viol, gerr);
    chk("b2b_word2", cap, a);

    // Reset asserted during the high phase of bit 30.
    d = {$urandom, $urandom};
    chk("abort_ready", 64'(bus.load_ready), 64'd1);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    nbad = 0;
    for (int k = 0; k <= ABORT_K; k++) begin
      @(negedge clk);
      if (pins() !== model(d, k, exp_en)) nbad++;
      if (k == 0) bus.load_valid = 1'b0;
    end
    chk("abort_pre_trace", 64'(nbad), 64'd0);
    rst = 1'b0;
    #1;
    chk("abort_immediate", 64'(pins()), 64'(6'b000001));
    repeat (2) @(negedge clk);
    chk("abort_held", 64'(pins()), 64'(6'b000001));
    clear_seq(1'b0);
    d = {$urandom, $urandom};
    run_frame(d, 1'b0, 64'd0, cap, rises, busy_n, viol, gerr);
    chk("post_abort_word", cap, d);

    for (int n = 0; n < 12; n++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("idle_gap", 64'({SEGCLK, bus.load_ready, bus.busy, SEGEN}),
            64'({1'b0, 1'b1, 1'b0, exp_en}));
      end
      d = {$urandom, $urandom};
      run_frame(d, 1'b0, 64'd0, cap, rises, busy_n, viol, gerr);
      chk("rand_word",      cap, d);
      chk("rand_dt_stable", 64'(viol), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
